// File: rtl/com_to_in_pkg.sv
// Shared definitions for the serial link: receiver state encoding, frame
// geometry and parity-mode constants common to transmitter and receiver.
package com_to_in_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rxState_t;

  localparam int DATA_BITS = 8;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

endpackage

// File: rtl/com_to_in_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle
// level so reset never looks like a start edge.
module rx_sync (
  input  logic clk,
  input  logic nReset,
  input  logic rx,
  output logic rxs
);

  logic [1:0] syncReg;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      syncReg <= 2'b11;
    end else begin
      syncReg <= {syncReg[0], rx};
    end
  end

  assign rxs = syncReg[1];

endmodule

// File: rtl/com_to_in.sv
// Serial receive stage: oversampled, centre-sampled UART-style receiver
// delivering a byte plus parity/framing flags per completed frame.
module com_to_in
  import com_to_in_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 enable,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 isReady,
  output logic                 parityErr,
  output logic                 frameErr,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic PARITY_TARGET = (PARITY_ODD != 1'b0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  rxState_t stateReg, stateNext;
  logic [TW-1:0]        tickReg;
  logic [2:0]           bitIdxReg;
  logic [DATA_BITS-1:0] shiftReg;
  logic [DATA_BITS-1:0] bitSel;
  logic                 parityBitReg;
  logic                 rxs;

  logic tickClear;
  logic bitIdxClear;
  logic sampleData;
  logic sampleParity;
  logic sampleStop;

  rx_sync uSync (
    .clk    (clk),
    .nReset (nReset),
    .rx     (rx),
    .rxs    (rxs)
  );

  // One-hot write select for the shift register slot addressed by the bit index.
  for (genvar gi = 0; gi < DATA_BITS; gi++) begin : gBitSel
    assign bitSel[gi] = (bitIdxReg == 3'(gi));
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      stateReg     <= IDLE;
      tickReg      <= '0;
      bitIdxReg    <= '0;
      shiftReg     <= '0;
      parityBitReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (enable) begin
        tickReg <= tickClear ? '0 : tickReg + 1'b1;
      end
      if (bitIdxClear) begin
        bitIdxReg <= '0;
      end else if (sampleData) begin
        bitIdxReg <= bitIdxReg + 1'b1;
      end
      if (sampleData) begin
        shiftReg <= (shiftReg & ~bitSel) | (bitSel & {DATA_BITS{rxs}});
      end
      if (sampleParity) begin
        parityBitReg <= rxs;
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    if (enable) begin
      unique case (stateReg)
        IDLE:    if (!rxs) stateNext = START;
        START:   if (tickReg == HALF_LAST) stateNext = rxs ? IDLE : DATA;
        DATA:    if (tickReg == FULL_LAST && bitIdxReg == LAST_BIT) stateNext = PARITY;
        PARITY:  if (tickReg == FULL_LAST) stateNext = STOP;
        STOP:    if (tickReg == FULL_LAST) stateNext = rxs ? IDLE : BREAK;
        BREAK:   if (rxs) stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // The tick counter is held at zero while idle so START always counts from its entry tick.
  always_comb begin
    busy         = (stateReg != IDLE);
    tickClear    = 1'b0;
    bitIdxClear  = 1'b0;
    sampleData   = 1'b0;
    sampleParity = 1'b0;
    sampleStop   = 1'b0;
    if (enable) begin
      unique case (stateReg)
        IDLE: tickClear = 1'b1;
        START: begin
          tickClear   = (tickReg == HALF_LAST);
          bitIdxClear = (tickReg == HALF_LAST) && !rxs;
        end
        DATA:    sampleData   = (tickReg == FULL_LAST);
        PARITY:  sampleParity = (tickReg == FULL_LAST);
        STOP:    sampleStop   = (tickReg == FULL_LAST);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      data      <= '0;
      isReady   <= 1'b0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      isReady <= sampleStop;
      if (sampleStop) begin
        data      <= shiftReg;
        parityErr <= ((^shiftReg) ^ parityBitReg) != PARITY_TARGET;
        frameErr  <= !rxs;
      end
    end
  end

endmodule

// File: tb/tb_com_to_in.sv
// Randomised, self-checking bench for com_to_in against a frame-level model.
module tb_com_to_in;

  localparam int OS  = 16;
  localparam bit ODD = 1'b0;
  localparam int DIV = 4;

  typedef struct {
    int         tick;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       enable = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       isReady;
  logic       parityErr;
  logic       frameErr;
  logic       busy;

  int   testsRun = 0;
  int   failCount = 0;
  int   tickCount = 0;
  int   divCnt = 0;
  bit   enableRun = 1'b1;
  bit   prevReady = 1'b0;
  int   widePulse = 0;
  rec_t got[$];

  com_to_in #(.OVERSAMPLE(OS), .PARITY_ODD(ODD)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .enable    (enable),
    .rx        (rx),
    .data      (data),
    .isReady   (isReady),
    .parityErr (parityErr),
    .frameErr  (frameErr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    divCnt = (divCnt + 1) % DIV;
    enable = (divCnt == 0) && enableRun;
  end

  always @(posedge clk) if (enable) tickCount++;

  always @(negedge clk) begin
    if (isReady === 1'b1) begin
      got.push_back('{tickCount, data, parityErr, frameErr});
      if (prevReady) widePulse++;
    end
    prevReady = (isReady === 1'b1);
  end

  function automatic logic modelParityErr(input logic [7:0] d, input logic p);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return ((ones % 2) != 0) ^ p ^ ODD;
  endfunction

  function automatic logic goodParity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return logic'(ones % 2) ^ ODD;
  endfunction

  task automatic tick();
    do @(posedge clk); while (!enable);
    #1;
  endtask

  task automatic waitTicks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic p, input logic stopBit, input int stallAt);
    logic [10:0] lv;
    lv = {stopBit, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = lv[i];
      if (i == stallAt) begin
        waitTicks(3);
        enableRun = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        enableRun = 1'b1;
        waitTicks(OS - 3);
      end else begin
        waitTicks(OS);
      end
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    testsRun++; if (data !== 8'h00) begin failCount++; $display("FAIL reset_data got %h want 00", data); end
    testsRun++; if (isReady !== 1'b0) begin failCount++; $display("FAIL reset_ready got %b want 0", isReady); end
    testsRun++; if (parityErr !== 1'b0) begin failCount++; $display("FAIL reset_pe got %b want 0", parityErr); end
    testsRun++; if (frameErr !== 1'b0) begin failCount++; $display("FAIL reset_fe got %b want 0", frameErr); end
    testsRun++; if (busy !== 1'b0) begin failCount++; $display("FAIL reset_busy got %b want 0", busy); end
    nReset = 1'b1;
    waitTicks(4);
    testsRun++; if (busy !== 1'b0 || got.size() != 0) begin failCount++; $display("FAIL idle_after_reset busy %b frames %0d want 0 0", busy, got.size()); end
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    int t0;
    rec_t r;
    got.delete();
    tick();
    t0 = tickCount;
    sendFrame(8'hA5, 1'b0, 1'b1, -1);
    waitTicks(2);
    testsRun++;
    if (got.size() != 1) begin
      failCount++; $display("FAIL basic_count got %0d want 1", got.size());
    end else begin
      r = got.pop_front();
      // Start edge lands between tick t0 and t0+1; detection at t0+1, stop sample 168 ticks later.
      testsRun++; if (r.tick - t0 != OS / 2 + 10 * OS + 1) begin failCount++; $display("FAIL basic_latency got %0d want %0d", r.tick - t0, OS / 2 + 10 * OS + 1); end
      testsRun++; if (r.d !== 8'hA5 || r.pe !== 1'b0 || r.fe !== 1'b0) begin failCount++; $display("FAIL basic_frame got %h pe%b fe%b want a5 pe0 fe0", r.d, r.pe, r.fe); end
    end
    $display("[TB] frame A5 sent");
  endtask

  task automatic test_parity();
    rec_t r;
    got.delete();
    sendFrame(8'h3C, 1'b1, 1'b1, -1);
    sendFrame(8'h01, 1'b1, 1'b1, -1);
    waitTicks(2);
    testsRun++;
    if (got.size() != 2) begin
      failCount++; $display("FAIL parity_count got %0d want 2", got.size());
    end else begin
      r = got.pop_front();
      testsRun++; if (r.d !== 8'h3C || r.pe !== 1'b1 || r.fe !== 1'b0) begin failCount++; $display("FAIL parity_bad got %h pe%b fe%b want 3c pe1 fe0", r.d, r.pe, r.fe); end
      r = got.pop_front();
      testsRun++; if (r.d !== 8'h01 || r.pe !== 1'b0 || r.fe !== 1'b0) begin failCount++; $display("FAIL parity_clear got %h pe%b fe%b want 01 pe0 fe0", r.d, r.pe, r.fe); end
    end
    $display("[TB] frames 3C 01 sent");
  endtask

  task automatic test_break();
    rec_t r;
    int busyLow = 0;
    got.delete();
    sendFrame(8'h7E, goodParity(8'h7E), 1'b0, -1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy !== 1'b1) busyLow++;
    end
    testsRun++; if (busyLow != 0) begin failCount++; $display("FAIL break_busy got %0d idle ticks want 0", busyLow); end
    testsRun++;
    if (got.size() != 1) begin
      failCount++; $display("FAIL break_count got %0d want 1", got.size());
    end else begin
      r = got.pop_front();
      testsRun++; if (r.d !== 8'h7E || r.fe !== 1'b1 || r.pe !== 1'b0) begin failCount++; $display("FAIL break_frame got %h pe%b fe%b want 7e pe0 fe1", r.d, r.pe, r.fe); end
    end
    rx = 1'b1;
    waitTicks(3);
    testsRun++; if (busy !== 1'b0) begin failCount++; $display("FAIL break_release got busy %b want 0", busy); end
    $display("[TB] frame 7E with break sent");
  endtask

  task automatic test_glitch();
    got.delete();
    rx = 1'b0;
    waitTicks(4);
    rx = 1'b1;
    waitTicks(OS / 2 - 4);
    testsRun++; if (busy !== 1'b1) begin failCount++; $display("FAIL glitch_busy got %b want 1", busy); end
    waitTicks(1);
    testsRun++; if (busy !== 1'b0) begin failCount++; $display("FAIL glitch_idle got %b want 0", busy); end
    waitTicks(20);
    testsRun++; if (got.size() != 0) begin failCount++; $display("FAIL glitch_ready got %0d want 0", got.size()); end
    $display("[TB] glitch applied");
  endtask

  task automatic test_back_to_back();
    rec_t r;
    got.delete();
    sendFrame(8'h00, goodParity(8'h00), 1'b1, -1);
    sendFrame(8'hFF, goodParity(8'hFF), 1'b1, -1);
    waitTicks(2);
    testsRun++;
    if (got.size() != 2) begin
      failCount++; $display("FAIL b2b_count got %0d want 2", got.size());
    end else begin
      r = got.pop_front();
      testsRun++; if (r.d !== 8'h00 || r.pe || r.fe) begin failCount++; $display("FAIL b2b_first got %h pe%b fe%b want 00 pe0 fe0", r.d, r.pe, r.fe); end
      r = got.pop_front();
      testsRun++; if (r.d !== 8'hFF || r.pe || r.fe) begin failCount++; $display("FAIL b2b_second got %h pe%b fe%b want ff pe0 fe0", r.d, r.pe, r.fe); end
    end
    testsRun++; if (widePulse != 0) begin failCount++; $display("FAIL ready_width got %0d wide pulses want 0", widePulse); end
    $display("[TB] frames 00 FF back to back");
  endtask

  task automatic test_reset_midframe();
    rec_t r;
    logic [7:0] d;
    got.delete();
    d = 8'h55;
    rx = 1'b0;
    waitTicks(OS);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      waitTicks(OS);
    end
    rx = d[4];
    waitTicks(OS / 2);
    nReset = 1'b0;
    @(posedge clk);
    #1;
    testsRun++; if (busy !== 1'b0 || data !== 8'h00 || isReady !== 1'b0 || parityErr !== 1'b0 || frameErr !== 1'b0)
      begin failCount++; $display("FAIL midreset_outputs got busy%b data %h rdy%b pe%b fe%b want 0 00 0 0 0", busy, data, isReady, parityErr, frameErr); end
    nReset = 1'b1;
    rx = 1'b1;
    waitTicks(2 * OS);
    testsRun++; if (got.size() != 0) begin failCount++; $display("FAIL midreset_ready got %0d want 0", got.size()); end
    got.delete();
    sendFrame(8'h81, goodParity(8'h81), 1'b1, -1);
    waitTicks(2);
    testsRun++;
    if (got.size() != 1) begin
      failCount++; $display("FAIL midreset_after_count got %0d want 1", got.size());
    end else begin
      r = got.pop_front();
      testsRun++; if (r.d !== 8'h81 || r.pe || r.fe) begin failCount++; $display("FAIL midreset_after got %h pe%b fe%b want 81 pe0 fe0", r.d, r.pe, r.fe); end
    end
    $display("[TB] reset during frame 55, then 81");
  endtask

  task automatic test_stall();
    rec_t r;
    got.delete();
    sendFrame(8'hC3, goodParity(8'hC3), 1'b1, 5);
    waitTicks(2);
    testsRun++;
    if (got.size() != 1) begin
      failCount++; $display("FAIL stall_count got %0d want 1", got.size());
    end else begin
      r = got.pop_front();
      testsRun++; if (r.d !== 8'hC3 || r.pe || r.fe) begin failCount++; $display("FAIL stall_frame got %h pe%b fe%b want c3 pe0 fe0", r.d, r.pe, r.fe); end
    end
    $display("[TB] frame C3 with enable stall");
  endtask

  task automatic test_random();
    rec_t r;
    logic [7:0] d;
    logic p, s;
    got.delete();
    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom);
      p = goodParity(d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 4) != 0);
      sendFrame(d, p, s, -1);
      rx = 1'b1;
      waitTicks(2 + $urandom_range(0, 20));
      testsRun++;
      if (got.size() != 1) begin
        failCount++; $display("FAIL rand%0d_count got %0d want 1", n, got.size());
        got.delete();
      end else begin
        r = got.pop_front();
        testsRun++;
        if (r.d !== d || r.pe !== modelParityErr(d, p) || r.fe !== !s) begin
          failCount++;
          $display("FAIL rand%0d got %h pe%b fe%b want %h pe%b fe%b", n, r.d, r.pe, r.fe, d, modelParityErr(d, p), !s);
        end
      end
      $display("[TB] random frame %0d data %h par %b stop %b", n, d, p, s);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
